// File: rtl/i2c_master_byte_seq_if.sv
// rtl/i2c_master_byte_seq_if.sv - host request/response and bit-controller signals of the byte sequencer
interface i2c_master_byte_seq_if #(
    parameter int BYTE_W = 8
);
    logic              ena;
    logic              start;
    logic              stop;
    logic              read;
    logic              write;
    logic              ack_in;
    logic [BYTE_W-1:0] din;
    logic              cmd_ack;
    logic              ack_out;
    logic [BYTE_W-1:0] dout;
    logic              i2c_al;
    logic [3:0]        bit_cmd;
    logic              bit_cmd_ack;
    logic              bit_al;
    logic              bit_din;
    logic              bit_dout;

    modport master (
        input  ena, start, stop, read, write, ack_in, din,
        input  bit_cmd_ack, bit_al, bit_dout,
        output cmd_ack, ack_out, dout, i2c_al, bit_cmd, bit_din
    );

    modport slave (
        output ena, start, stop, read, write, ack_in, din,
        output bit_cmd_ack, bit_al, bit_dout,
        input  cmd_ack, ack_out, dout, i2c_al, bit_cmd, bit_din
    );
endinterface

// File: rtl/i2c_master_byte_seq.sv
// rtl/i2c_master_byte_seq.sv - byte-level I2C sequencer issuing START/WRITE/READ/STOP bit commands
module i2c_master_byte_seq #(
    parameter int BYTE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    i2c_master_byte_seq_if.master  bus
);
    localparam int CNT_W = (BYTE_W > 2) ? $clog2(BYTE_W) : 1;

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        bit_cmd_q, bit_cmd_d;
    logic              bit_din_q, bit_din_d;
    logic              cmd_ack_q, cmd_ack_d;
    logic              i2c_al_q, i2c_al_d;
    logic              ack_out_q, ack_out_d;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] sr_shift;
    logic              go;

    // Masking with cmd_ack stops a still-held request from relaunching in its own completion cycle.
    assign go       = (bus.read | bus.write | bus.stop) & ~cmd_ack_q;
    assign sr_shift = {sr_q[BYTE_W-2:0], bus.bit_dout};

    always_comb begin
        state_d   = state_q;
        bit_cmd_d = bit_cmd_q;
        bit_din_d = bit_din_q;
        cmd_ack_d = 1'b0;
        i2c_al_d  = 1'b0;
        ack_out_d = ack_out_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;

        if (bus.bit_al) begin
            state_d   = ST_IDLE;
            bit_cmd_d = CMD_NOP;
            bit_din_d = 1'b1;
            i2c_al_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        sr_d  = bus.din;
                        cnt_d = CNT_W'(BYTE_W - 1);
                        // A stop-only request never emits START.
                        if (bus.start && (bus.read || bus.write)) begin
                            state_d   = ST_START;
                            bit_cmd_d = CMD_START;
                        end else if (bus.read) begin
                            state_d   = ST_READ;
                            bit_cmd_d = CMD_READ;
                        end else if (bus.write) begin
                            state_d   = ST_WRITE;
                            bit_cmd_d = CMD_WRITE;
                            bit_din_d = bus.din[BYTE_W-1];
                        end else begin
                            state_d   = ST_STOP;
                            bit_cmd_d = CMD_STOP;
                        end
                    end
                end
                ST_START: begin
                    if (bus.bit_cmd_ack) begin
                        if (bus.read) begin
                            state_d   = ST_READ;
                            bit_cmd_d = CMD_READ;
                        end else begin
                            state_d   = ST_WRITE;
                            bit_cmd_d = CMD_WRITE;
                            bit_din_d = sr_q[BYTE_W-1];
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (bus.bit_cmd_ack) begin
                        sr_d = sr_shift;
                        if (cnt_q != '0) begin
                            cnt_d     = cnt_q - 1'b1;
                            bit_din_d = sr_shift[BYTE_W-1];
                        end else begin
                            state_d = ST_ACK;
                            if (state_q == ST_WRITE) begin
                                bit_cmd_d = CMD_READ;
                            end else begin
                                bit_cmd_d = CMD_WRITE;
                                bit_din_d = bus.ack_in;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.bit_cmd_ack) begin
                        ack_out_d = bus.bit_dout;
                        bit_din_d = 1'b1;
                        if (bus.stop) begin
                            state_d   = ST_STOP;
                            bit_cmd_d = CMD_STOP;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_cmd_d = CMD_NOP;
                            cmd_ack_d = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.bit_cmd_ack) begin
                        state_d   = ST_IDLE;
                        bit_cmd_d = CMD_NOP;
                        cmd_ack_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cmd_d = CMD_NOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.ena) begin
            state_q   <= ST_IDLE;
            bit_cmd_q <= CMD_NOP;
            bit_din_q <= 1'b1;
            cmd_ack_q <= 1'b0;
            i2c_al_q  <= 1'b0;
            ack_out_q <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cmd_q <= bit_cmd_d;
            bit_din_q <= bit_din_d;
            cmd_ack_q <= cmd_ack_d;
            i2c_al_q  <= i2c_al_d;
            ack_out_q <= ack_out_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.bit_cmd = bit_cmd_q;
    assign bus.bit_din = bit_din_q;
    assign bus.cmd_ack = cmd_ack_q;
    assign bus.i2c_al  = i2c_al_q;
    assign bus.ack_out = ack_out_q;
    assign bus.dout    = sr_q;
endmodule

// File: tb/tb_i2c_master_byte_seq.sv
// tb/tb_i2c_master_byte_seq.sv - bench for i2c_master_byte_seq with a request-level bit-command model
`timescale 1ns/1ps
module tb_i2c_master_byte_seq;
    localparam int BW = 8;
    localparam logic [3:0] C_NOP = 4'b0000, C_START = 4'b0001, C_STOP = 4'b0010,
                           C_WRITE = 4'b0100, C_READ = 4'b1000;

    typedef struct packed {
        logic [3:0] cmd;
        logic       din;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_byte_seq_if #(.BYTE_W(BW)) bus();
    i2c_master_byte_seq #(.BYTE_W(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic r_ack = 1'b0, r_al = 1'b0, r_dout = 1'b0;
    assign bus.bit_cmd_ack = r_ack;
    assign bus.bit_al      = r_al;
    assign bus.bit_dout    = r_dout;

    int n_tests = 0, n_fail = 0, cyc = 0;
    ent_t log_q[$], exp_q[$];
    logic [7:0] exp_dout = '0, slave_byte = '0;
    logic m_ack_out = 1'b0, slave_ack = 1'b0, saved_ack = 1'b0, prev_al = 1'b0;
    bit exp_active = 0, al_exp = 0, cur_rd = 0, rsp_hold = 0, al_with_ack = 0, ok = 0;
    int done_cnt = 0, al_cnt = 0, last_ack_cyc = 0, rsp_lat = 1, wait_cnt = 0, al_at = -1, nreads = 0, a0 = 0;
    logic [7:0] bits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-controller stand-in: acks each command after rsp_lat idle cycles, returns SDA values.
    task automatic rsp_step();
        if (r_ack || r_al) begin
            r_ack = 1'b0; r_al = 1'b0; wait_cnt = 0;
        end else if (bus.bit_cmd == C_NOP || rsp_hold) begin
            wait_cnt = 0;
        end else if (wait_cnt < rsp_lat) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            log_q.push_back({bus.bit_cmd, bus.bit_din});
            last_ack_cyc = cyc;
            if (al_at >= 0 && log_q.size() == al_at + 1) begin
                r_al = 1'b1; r_ack = al_with_ack;
            end else begin
                r_ack = 1'b1;
                if (bus.bit_cmd == C_WRITE) r_dout = bus.bit_din;
                else if (bus.bit_cmd == C_READ) begin
                    if (cur_rd && nreads < 8) begin r_dout = slave_byte[7-nreads]; nreads++; end
                    else r_dout = slave_ack;
                end else r_dout = 1'b0;
            end
        end
    endtask

    task automatic mon_step();
        int bad;
        chk("bit_cmd_legal", {31'd0, bus.bit_cmd inside {C_NOP, C_START, C_STOP, C_WRITE, C_READ}}, 1);
        if (bus.cmd_ack) begin
            chk("cmd_ack_expected", {31'd0, exp_active}, 1);
            if (exp_active) begin
                bad = -1;
                for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
                    if (bad < 0 && (log_q[i].cmd !== exp_q[i].cmd ||
                        (exp_q[i].cmd == C_WRITE && log_q[i].din !== exp_q[i].din))) bad = i;
                chk("seq_len", log_q.size(), exp_q.size());
                chk("seq_first_bad_idx", bad, -1);
                chk("dout", bus.dout, exp_dout);
                chk("ack_out", bus.ack_out, m_ack_out);
                chk("cmd_ack_latency", cyc, last_ack_cyc + 1);
                exp_active = 0;
                done_cnt++;
            end
        end
        if (bus.i2c_al) begin
            chk("i2c_al_expected", {31'd0, al_exp}, 1);
            chk("i2c_al_single", {31'd0, prev_al}, 0);
            chk("al_bit_cmd", bus.bit_cmd, C_NOP);
            chk("al_bit_din", bus.bit_din, 1);
            chk("al_no_cmd_ack", bus.cmd_ack, 0);
            al_exp = 0;
            al_cnt++;
        end
        prev_al = bus.i2c_al;
    endtask

    // Expected command stream derived from the request alone.
    task automatic launch(input bit s, input bit p, input bit rd, input bit wr,
                          input logic [7:0] d, input logic ai, input logic [7:0] sb);
        log_q.delete(); exp_q.delete();
        nreads = 0; cur_rd = rd; slave_byte = sb;
        if (rd || wr) begin
            if (s) exp_q.push_back({C_START, 1'b0});
            for (int i = 7; i >= 0; i--) exp_q.push_back(rd ? {C_READ, 1'b0} : {C_WRITE, d[i]});
            exp_q.push_back(rd ? {C_WRITE, ai} : {C_READ, 1'b0});
            m_ack_out = rd ? ai : slave_ack;
        end
        if (p) exp_q.push_back({C_STOP, 1'b0});
        exp_dout = rd ? sb : d;
        exp_active = 1;
        bus.start = s; bus.stop = p; bus.read = rd; bus.write = wr; bus.din = d; bus.ack_in = ai;
    endtask

    task automatic host_idle();
        bus.start = 0; bus.stop = 0; bus.read = 0; bus.write = 0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        bit got;
        d0 = done_cnt; got = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) got = 1;
        end
        chk({name, "_completed"}, {31'd0, got}, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bit_cmd"}, bus.bit_cmd, C_NOP);
        chk({tag, "_bit_din"}, bus.bit_din, 1);
        chk({tag, "_cmd_ack"}, bus.cmd_ack, 0);
        chk({tag, "_i2c_al"},  bus.i2c_al, 0);
        chk({tag, "_ack_out"}, bus.ack_out, 0);
        chk({tag, "_dout"},    bus.dout, 0);
    endtask

    task automatic wait_log(input int n, input string name);
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk); #1;
            if (log_q.size() >= n) ok = 1;
        end
        chk(name, {31'd0, ok}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ena = 1; bus.din = '0; bus.ack_in = 0;
        host_idle();
        fork
            forever begin
                @(negedge clk);
                cyc++;
                rsp_step();
                mon_step();
            end
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");
        rst = 0;

        // Write with START and STOP, slave ACKs.
        slave_ack = 0; rsp_lat = 1;
        launch(1, 1, 0, 1, 8'hA5, 0, 8'h00);
        wait_done("t1");
        host_idle();
        chk("t1_len", log_q.size(), 11);
        bits = '0;
        if (log_q.size() == 11) for (int i = 0; i < 8; i++) bits[7-i] = log_q[1+i].din;
        chk("t1_bits", bits, 8'hA5);
        chk("t1_ack_out", bus.ack_out, 0);
        chk("t1_last", (log_q.size() == 11) ? log_q[10].cmd : 4'hF, C_STOP);

        // Read with NACK, no START/STOP, zero responder latency.
        rsp_lat = 0;
        launch(0, 0, 1, 0, 8'h00, 1, 8'h3C);
        wait_done("t2");
        host_idle();
        chk("t2_dout", bus.dout, 8'h3C);
        chk("t2_len", log_q.size(), 9);
        chk("t2_ack_bit", (log_q.size() == 9) ? log_q[8] : 5'h1F, {C_WRITE, 1'b1});

        // Stop-only: single STOP, ack_out untouched.
        rsp_lat = 2;
        launch(0, 1, 0, 0, 8'h5A, 0, 8'h00);
        wait_done("t3");
        host_idle();
        chk("t3_len", log_q.size(), 1);
        chk("t3_ack_out_kept", bus.ack_out, 1);

        // Arbitration lost on the 4th data bit, coincident with its ack.
        rsp_lat = 1; al_at = 3; al_with_ack = 1; saved_ack = m_ack_out;
        launch(0, 0, 0, 1, 8'h96, 0, 8'h00);
        m_ack_out = saved_ack; exp_active = 0; al_exp = 1;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk); #1;
            if (r_al) ok = 1;
        end
        chk("t4_al_raised", {31'd0, ok}, 1);
        host_idle();
        a0 = al_cnt; ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk); #1;
            if (al_cnt != a0) ok = 1;
        end
        chk("t4_al_seen", {31'd0, ok}, 1);
        chk("t4_len", log_q.size(), 4);
        al_at = -1; al_with_ack = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("t4_idle_nop", bus.bit_cmd, C_NOP);
        slave_ack = 1;
        launch(1, 0, 0, 1, 8'h0F, 0, 8'h00);
        wait_done("t4_after");
        host_idle();
        chk("t4_after_ack_out", bus.ack_out, 1);

        // Reset pulsed mid-read, request held so it restarts.
        slave_ack = 0;
        launch(0, 1, 1, 0, 8'h00, 0, 8'hC3);
        wait_log(3, "t5_progress");
        rsp_hold = 1; rst = 1;
        @(negedge clk); #1;
        chk_reset("t5_rst");
        m_ack_out = 0;
        rst = 0; rsp_hold = 0;
        launch(0, 1, 1, 0, 8'h00, 0, 8'hC3);
        wait_done("t5");
        host_idle();

        // ena dropped mid-write.
        slave_ack = 1;
        launch(1, 0, 0, 1, 8'h6E, 0, 8'h00);
        wait_log(4, "t6_progress");
        rsp_hold = 1; bus.ena = 0;
        @(negedge clk); #1;
        chk_reset("t6_ena");
        m_ack_out = 0;
        bus.ena = 1; rsp_hold = 0;
        launch(1, 0, 0, 1, 8'h6E, 0, 8'h00);
        wait_done("t6");
        host_idle();

        // Back-to-back with held bits: one transfer per cmd_ack.
        slave_ack = 0; a0 = done_cnt;
        launch(0, 0, 0, 1, 8'h81, 0, 8'h00);
        wait_done("t7a");
        launch(0, 0, 0, 1, 8'h81, 0, 8'h00);
        wait_done("t7b");
        launch(0, 1, 1, 0, 8'h00, 0, 8'h7E);
        wait_done("t7c");
        host_idle();
        repeat (30) @(negedge clk);
        #1;
        chk("t7_count", done_cnt - a0, 3);
        chk("t7_final_dout", bus.dout, 8'h7E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
